// File: rtl/main_ctrl_mc.sv
// rtl/main_ctrl_mc.sv - camera main-control FSM: data-move gating, config-ack handshake, TOE preemption, shutdown and fault
module main_ctrl_mc #(
  parameter int NUM_CH      = 4,
  parameter int CMD_PERIOD  = 16,
  parameter int ACK_TIMEOUT = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              toe_busy,
  output logic [NUM_CH-1:0] move_en,
  input  logic [NUM_CH-1:0] move_done,
  input  logic              cfg_done,
  input  logic              shutdown,
  input  logic              cmd_done,
  output logic              cmd_tx,
  output logic [1:0]        cmd_type,
  output logic              frm_tx_en,
  output logic              ack,
  output logic              fault,
  input  logic              fault_clr,
  output logic [6:0]        fsm_state
);

  typedef enum logic [6:0] {
    S_WAIT_MOVE = 7'b0000001,
    S_TOE       = 7'b0000010,
    S_WAIT_CFG  = 7'b0000100,
    S_CFG_ACK   = 7'b0001000,
    S_SEND_DATA = 7'b0010000,
    S_SHUT_DOWN = 7'b0100000,
    S_FAULT     = 7'b1000000
  } state_e;

  localparam int PW = (CMD_PERIOD > 1) ? $clog2(CMD_PERIOD) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(CMD_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]    MAX_R    = 4'(MAX_RETRY);

  localparam logic [1:0] CMD_CFG   = 2'b01;
  localparam logic [1:0] CMD_SHUT  = 2'b10;
  localparam logic [1:0] CMD_FAULT = 2'b11;

  state_e            state_q, state_d;
  state_e            ret_state_q, ret_state_d;
  logic [NUM_CH-1:0] done_mask_q, done_mask_d;
  logic [NUM_CH-1:0] move_en_q, move_en_d;
  logic              cmd_tx_q, cmd_tx_d;
  logic [1:0]        cmd_type_q, cmd_type_d;
  logic              frm_tx_en_q, frm_tx_en_d;
  logic              ack_q, ack_d;
  logic              fault_q, fault_d;
  logic [PW-1:0]     per_cnt_q, per_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        retry_q, retry_d;
  logic              per_fire;
  logic              illegal;

  // Next-state, counter and registered-output computation; outputs follow the next state
  always_comb begin
    state_d     = state_q;
    ret_state_d = ret_state_q;
    done_mask_d = done_mask_q | move_done;
    cmd_tx_d    = 1'b0;
    cmd_type_d  = cmd_type_q;
    per_fire    = (per_cnt_q == PER_LAST);
    per_cnt_d   = per_fire ? '0 : per_cnt_q + 1'b1;
    timer_d     = timer_q + 1'b1;
    retry_d     = retry_q;
    illegal     = 1'b0;

    case (state_q)
      S_WAIT_MOVE: begin
        if (toe_busy) begin
          state_d     = S_TOE;
          ret_state_d = S_WAIT_MOVE;
        end else if (&done_mask_d) begin
          state_d     = S_WAIT_CFG;
          done_mask_d = '0;
        end
      end
      S_TOE: begin
        if (!toe_busy) state_d = ret_state_q;
      end
      S_WAIT_CFG: begin
        if (toe_busy) begin
          state_d     = S_TOE;
          ret_state_d = S_WAIT_CFG;
        end else if (cfg_done) begin
          state_d = S_CFG_ACK;
        end else if (per_fire) begin
          cmd_tx_d   = 1'b1;
          cmd_type_d = CMD_CFG;
        end
      end
      S_CFG_ACK: begin
        if (toe_busy) begin
          state_d     = S_TOE;
          ret_state_d = S_CFG_ACK;
        end else if (cmd_done) begin
          state_d = S_SEND_DATA;
        end else if (timer_q == TO_LAST) begin
          if (retry_q < MAX_R) begin
            cmd_tx_d   = 1'b1;
            cmd_type_d = CMD_CFG;
            retry_d    = retry_q + 1'b1;
            timer_d    = '0;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_SEND_DATA: begin
        if (toe_busy) begin
          state_d     = S_TOE;
          ret_state_d = S_SEND_DATA;
        end else if (shutdown) begin
          state_d = S_SHUT_DOWN;
        end else if (cfg_done) begin
          state_d = S_CFG_ACK;
        end
      end
      S_SHUT_DOWN: begin
        if (cfg_done) begin
          state_d = S_CFG_ACK;
        end else if (per_fire) begin
          cmd_tx_d   = 1'b1;
          cmd_type_d = CMD_SHUT;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_d     = S_WAIT_MOVE;
          done_mask_d = '0;
        end
      end
      default: illegal = 1'b1;
    endcase

    // Entry actions: the period counter restarts, CFG_ACK and FAULT own their entry command
    if (!illegal && (state_d != state_q)) begin
      per_cnt_d = '0;
      if (state_d == S_CFG_ACK) begin
        cmd_tx_d   = 1'b1;
        cmd_type_d = CMD_CFG;
        timer_d    = '0;
        retry_d    = '0;
      end else if (state_d == S_FAULT) begin
        cmd_tx_d   = 1'b1;
        cmd_type_d = CMD_FAULT;
      end
    end

    move_en_d   = (state_d == S_WAIT_MOVE) ? ~done_mask_d : '0;
    frm_tx_en_d = (state_d == S_SEND_DATA);
    ack_d       = (state_d == S_CFG_ACK);
    fault_d     = (state_d == S_FAULT);

    // A corrupted state register recovers to the reset picture
    if (illegal) begin
      state_d     = S_WAIT_MOVE;
      ret_state_d = S_WAIT_MOVE;
      done_mask_d = '0;
      move_en_d   = '1;
      cmd_tx_d    = 1'b0;
      cmd_type_d  = 2'b00;
      frm_tx_en_d = 1'b0;
      ack_d       = 1'b0;
      fault_d     = 1'b0;
      per_cnt_d   = '0;
      timer_d     = '0;
      retry_d     = '0;
    end
  end

  // State and registered outputs, cleared immediately by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT_MOVE;
      ret_state_q <= S_WAIT_MOVE;
      done_mask_q <= '0;
      move_en_q   <= '1;
      cmd_tx_q    <= 1'b0;
      cmd_type_q  <= 2'b00;
      frm_tx_en_q <= 1'b0;
      ack_q       <= 1'b0;
      fault_q     <= 1'b0;
      per_cnt_q   <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      done_mask_q <= done_mask_d;
      move_en_q   <= move_en_d;
      cmd_tx_q    <= cmd_tx_d;
      cmd_type_q  <= cmd_type_d;
      frm_tx_en_q <= frm_tx_en_d;
      ack_q       <= ack_d;
      fault_q     <= fault_d;
      per_cnt_q   <= per_cnt_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
    end
  end

  assign move_en   = move_en_q;
  assign cmd_tx    = cmd_tx_q;
  assign cmd_type  = cmd_type_q;
  assign frm_tx_en = frm_tx_en_q;
  assign ack       = ack_q;
  assign fault     = fault_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_main_ctrl_mc.sv
// tb/tb_main_ctrl_mc.sv - directed self-checking bench for main_ctrl_mc
module tb_main_ctrl_mc;

  localparam int NUM_CH = 4;

  localparam logic [6:0] ST_WM = 7'd1;
  localparam logic [6:0] ST_TOE = 7'd2;
  localparam logic [6:0] ST_WC = 7'd4;
  localparam logic [6:0] ST_CA = 7'd8;
  localparam logic [6:0] ST_SD = 7'd16;
  localparam logic [6:0] ST_SH = 7'd32;
  localparam logic [6:0] ST_FT = 7'd64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              toe_busy;
  logic [NUM_CH-1:0] move_en;
  logic [NUM_CH-1:0] move_done;
  logic              cfg_done;
  logic              shutdown;
  logic              cmd_done;
  logic              cmd_tx;
  logic [1:0]        cmd_type;
  logic              frm_tx_en;
  logic              ack;
  logic              fault;
  logic              fault_clr;
  logic [6:0]        fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  main_ctrl_mc #(
    .NUM_CH(NUM_CH), .CMD_PERIOD(16), .ACK_TIMEOUT(8), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .toe_busy(toe_busy), .move_en(move_en),
    .move_done(move_done), .cfg_done(cfg_done), .shutdown(shutdown),
    .cmd_done(cmd_done), .cmd_tx(cmd_tx), .cmd_type(cmd_type),
    .frm_tx_en(frm_tx_en), .ack(ack), .fault(fault), .fault_clr(fault_clr),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_count(input int n, output int pulses, output int frm_hi);
    pulses = 0;
    frm_hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cmd_tx) pulses++;
      if (frm_tx_en) frm_hi++;
    end
  endtask

  initial begin
    int p;
    int f;
    rst_n = 1'b0; toe_busy = 1'b0; move_done = '0; cfg_done = 1'b0;
    shutdown = 1'b0; cmd_done = 1'b0; fault_clr = 1'b0;
    tick(); tick();
    check("rst_state", fsm_state, ST_WM);
    check("rst_move_en", move_en, 4'hF);
    check("rst_cmd_tx", cmd_tx, 0);
    check("rst_cmd_type", cmd_type, 0);
    check("rst_outs", {frm_tx_en, ack, fault}, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_state", fsm_state, ST_WM);

    // move_done bits 0 and 2, then bit 1 while preempted by TOE, then bit 3
    move_done = 4'b0001; tick(); move_done = '0;
    check("move_en_b0", move_en, 4'hE);
    move_done = 4'b0100; tick(); move_done = '0;
    check("move_en_b2", move_en, 4'hA);
    toe_busy = 1'b1; tick();
    check("toe_from_wm", fsm_state, ST_TOE);
    check("toe_move_en", move_en, 4'h0);
    move_done = 4'b0010; tick(); move_done = '0;
    toe_busy = 1'b0; tick();
    check("toe_ret_wm", fsm_state, ST_WM);
    check("toe_mask_kept", move_en, 4'h8);
    move_done = 4'b1000; tick(); move_done = '0;
    check("to_wait_cfg", fsm_state, ST_WC);
    check("wc_move_en", move_en, 4'h0);

    // periodic INIT command every 16 cycles
    run_count(15, p, f);
    check("wc_quiet1", p, 0);
    tick();
    check("wc_fire1", {cmd_tx, cmd_type}, 3'b101);
    run_count(15, p, f);
    check("wc_quiet2", p, 0);
    tick();
    check("wc_fire2", {cmd_tx, cmd_type}, 3'b101);

    // cfg_done -> CFG_ACK with one entry command, cmd_done 5 cycles later
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    check("ca_state", fsm_state, ST_CA);
    check("ca_entry", {ack, cmd_tx, cmd_type}, 4'b1101);
    run_count(4, p, f);
    check("ca_single_cmd", p, 0);
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    check("sd_state", fsm_state, ST_SD);
    check("sd_outs", {frm_tx_en, ack}, 2'b10);

    // TOE for 20 cycles during SEND_DATA
    toe_busy = 1'b1;
    move_done = 4'b0001;
    tick();
    move_done = '0;
    check("sd_toe_state", fsm_state, ST_TOE);
    run_count(19, p, f);
    check("sd_toe_frm", f, 0);
    check("sd_toe_cmd", p, 0);
    toe_busy = 1'b0; tick();
    check("sd_toe_ret", fsm_state, ST_SD);
    check("sd_toe_frm_back", frm_tx_en, 1);

    // shutdown wins over simultaneous cfg_done
    shutdown = 1'b1; cfg_done = 1'b1; tick(); shutdown = 1'b0; cfg_done = 1'b0;
    check("sh_state", fsm_state, ST_SH);
    check("sh_entry", {frm_tx_en, cmd_tx}, 2'b00);
    run_count(15, p, f);
    check("sh_quiet1", p, 0);
    tick();
    check("sh_fire1", {cmd_tx, cmd_type}, 3'b110);
    run_count(15, p, f);
    check("sh_quiet2", p, 0);
    tick();
    check("sh_fire2", {cmd_tx, cmd_type}, 3'b110);
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    check("sh_to_ca", {fsm_state, ack, cmd_tx, cmd_type}, {ST_CA, 4'b1101});

    // ack timeout: re-sends at +8 and +16, FAULT at +24
    run_count(7, p, f);
    check("to_quiet1", p, 0);
    tick();
    check("to_resend1", {fsm_state, cmd_tx, cmd_type}, {ST_CA, 3'b101});
    run_count(7, p, f);
    check("to_quiet2", p, 0);
    tick();
    check("to_resend2", {fsm_state, cmd_tx, cmd_type}, {ST_CA, 3'b101});
    run_count(7, p, f);
    check("to_quiet3", p, 0);
    tick();
    check("fault_state", fsm_state, ST_FT);
    check("fault_entry", {fault, ack, cmd_tx, cmd_type}, 5'b10111);
    toe_busy = 1'b1; tick(); toe_busy = 1'b0;
    check("fault_no_toe", {fsm_state, cmd_tx, move_en}, {ST_FT, 1'b0, 4'h0});
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("fault_clr", {fsm_state, move_en, fault}, {ST_WM, 4'hF, 1'b0});

    // cmd_done in the timeout cycle wins over the re-send
    move_done = 4'hF; tick(); move_done = '0;
    check("all_done_once", fsm_state, ST_WC);
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    run_count(7, p, f);
    check("win_quiet", p, 0);
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    check("win_state", {fsm_state, cmd_tx}, {ST_SD, 1'b0});

    // preemption beats shutdown in the same cycle
    toe_busy = 1'b1; shutdown = 1'b1; tick(); shutdown = 1'b0;
    check("preempt_prio", fsm_state, ST_TOE);
    toe_busy = 1'b0; tick();
    check("preempt_ret", fsm_state, ST_SD);

    // async reset mid-timeout in CFG_ACK
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    check("reconf_ca", fsm_state, ST_CA);
    run_count(3, p, f);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", fsm_state, ST_WM);
    check("async_rst_outs", {move_en, cmd_tx, cmd_type, frm_tx_en, ack, fault}, {4'hF, 6'b0});
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_release", {fsm_state, move_en, cmd_tx}, {ST_WM, 4'hF, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
